// File: rtl/return_stack_ram.sv
// Return-address stack storage: owns the stack pointer, performs push/pop into a private
// synchronous RAM and returns popped addresses with a one-cycle valid pulse.
module return_stack_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Store_RAM_signal,
  input  logic                  Load_RAM_signal,
  input  logic [31:0]           Top_Stack_new,
  input  logic [DATA_WIDTH-1:0] Return_Addr_in,
  output logic [31:0]           Top_Stack_old,
  output logic [DATA_WIDTH-1:0] Return_Addr_out,
  output logic                  Return_valid,
  output logic                  Busy,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StPopRd,
    StPopOut
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  we, re;
  logic                  full, empty;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Upper pointer bits from upstream are trusted to be zero and deliberately dropped.
  logic unused_top_stack_new;
  assign unused_top_stack_new = ^Top_Stack_new[31:ADDR_WIDTH+1];

  assign full  = (ptr_q == (ADDR_WIDTH+1)'(Depth));
  assign empty = (ptr_q == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Store_RAM_signal && !Load_RAM_signal) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            ptr_d = Top_Stack_new[ADDR_WIDTH:0];
          end
        end else if (Load_RAM_signal && !Store_RAM_signal) begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            re      = 1'b1;
            ptr_d   = Top_Stack_new[ADDR_WIDTH:0];
            state_d = StPopRd;
          end
        end
      end
      StPopRd:  state_d = StPopOut;
      StPopOut: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (state_q == StPopRd) begin
        out_q <= rd_data_q;
      end
    end
  end

  // RAM array and its read register carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr_q[ADDR_WIDTH-1:0]] <= Return_Addr_in;
    end
    if (re) begin
      rd_data_q <= mem[Top_Stack_new[ADDR_WIDTH-1:0]];
    end
  end

  assign Top_Stack_old   = {{(32 - ADDR_WIDTH - 1){1'b0}}, ptr_q};
  assign Return_Addr_out = out_q;
  assign Return_valid    = (state_q == StPopOut);
  assign Busy            = (state_q != StIdle);
  assign Overflow        = ovf_q;
  assign Underflow       = unf_q;

endmodule

// File: doc/return_stack_ram.md
Name: return_stack_ram

Overview:
- Return-address stack storage stage sitting directly downstream of the stack pointer logic (`Stack_Memory`).
- Owns the stack-pointer register that feeds `Top_Stack_old` back upstream.
- Consumes `Top_Stack_new`, `Store_RAM_signal` and `Load_RAM_signal`; performs the actual push/pop of return addresses in a private synchronous RAM.
- Delivers popped addresses to the PC-select logic with a valid pulse, and stalls the front end while a pop is in flight.

Parameters:
- DATA_WIDTH, 32, width of a stored return address.
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH entries (16).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- Store_RAM_signal  input  1  push request from stack pointer logic (JAL)
- Load_RAM_signal  input  1  pop request from stack pointer logic (JS)
- Top_Stack_new  input  32  next pointer value computed upstream
- Return_Addr_in  input  DATA_WIDTH  return address (PC+1) to push
- Top_Stack_old  output  32  current pointer, zero-extended from internal ADDR_WIDTH+1-bit count
- Return_Addr_out  output  DATA_WIDTH  popped return address
- Return_valid  output  1  one-cycle pulse: Return_Addr_out is valid
- Busy  output  1  high while a pop is in progress; upstream must hold requests
- Overflow  output  1  sticky: push attempted when full
- Underflow  output  1  sticky: pop attempted when empty

Behaviour:
- Clock and reset:
  - Single clock domain `clk`.
  - Asynchronous active-low reset `rst_n`.
  - On reset: pointer = 0, Top_Stack_old = 0, Return_Addr_out = 0, Return_valid = 0, Busy = 0, Overflow = 0, Underflow = 0, FSM = IDLE.
  - RAM contents are not reset (don't-care).
- Internal pointer:
  - ptr is ADDR_WIDTH+1 bits, range 0..16.
  - Full when ptr == 2**ADDR_WIDTH; empty when ptr == 0.
- FSM states: IDLE, POP_RD, POP_OUT.
  - Busy = (state != IDLE).
  - Requests are sampled only in IDLE; requests while Busy are ignored with no side effects.
- Push (IDLE, Store = 1, Load = 0):
  - If not full: at the same edge, RAM[ptr[ADDR_WIDTH-1:0]] <= Return_Addr_in and ptr <= Top_Stack_new[ADDR_WIDTH:0].
  - FSM stays IDLE; single-cycle, back-to-back pushes allowed.
  - If full: no write, ptr unchanged, Overflow <= 1.
- Pop (IDLE, Load = 1, Store = 0):
  - If not empty:
    - Edge 0: ptr <= Top_Stack_new[ADDR_WIDTH:0]; synchronous RAM read issued at address Top_Stack_new[ADDR_WIDTH-1:0] (= old-1); FSM -> POP_RD.
    - Edge 1: read data registered into Return_Addr_out; FSM -> POP_OUT.
    - In POP_OUT, Return_valid = 1 for exactly one cycle; next edge FSM -> IDLE.
  - Latency: request edge to valid = 2 cycles.
  - If empty: no read, ptr unchanged, Underflow <= 1, FSM stays IDLE, no valid pulse.
- Simultaneous Store and Load in IDLE: treated as illegal. No RAM access, ptr unchanged, both Overflow and Underflow unaffected, request dropped.
- Return_Addr_out holds its last popped value until the next pop completes.
- Sticky flags clear only on reset.
- Reset mid-pop (POP_RD or POP_OUT): immediate return to IDLE. Return_valid drops asynchronously, ptr = 0, no valid pulse is produced.
- Pointer consistency: the block trusts Top_Stack_new; only bits [ADDR_WIDTH:0] are stored, upper bits are ignored.

Test Plan:
- Reset then three pushes of 0x00000010, 0x00000020, 0x00000030 (Top_Stack_new 1, 2, 3) -> Top_Stack_old = 3, Busy never high.
- Pop from ptr 3 (Top_Stack_new = 2):
  - Busy high for 2 cycles.
  - Return_valid pulses once, 2 cycles after the request edge, with Return_Addr_out = 0x00000030.
  - Top_Stack_old = 2.
- Empty stack pop (ptr 0) -> Underflow = 1, Return_valid stays 0, Top_Stack_old = 0.
- 16 pushes then a 17th push of 0xDEADBEEF -> Overflow = 1, Top_Stack_old = 16; next 16 pops return values in LIFO order, and 0xDEADBEEF never appears.
- Store and Load both high at ptr 2 -> ptr stays 2, no valid pulse, flags unchanged. A push issued during Busy -> ignored, ptr unchanged.
- Pop issued, rst_n asserted in POP_RD -> Busy = 0 and Top_Stack_old = 0 immediately; no Return_valid pulse after reset release.
